// File: rtl/lfsr_pkg.sv
// Shared types and constants for the shared 7-bit LFSR arbiter.
// Used by lfsr_share_arbiter, which also honours the optional ARB_FIXED_PRIO_EN macro.
package lfsr_pkg;

    localparam int LFSR_W = 7;
    localparam int TAP_HI = 6;
    localparam int TAP_LO = 5;
    localparam int PERIOD = 127;
    localparam int CNT_W  = 7;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        ARB,
        ISSUE
    } state_t;

    // Maximal-length polynomial: shift left and feed q[6]^q[5] into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], cur[TAP_HI] ^ cur[TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr7_core.sv
// 7-bit Fibonacci LFSR register with synchronous reset, seed load and single-step advance.
// A load takes priority over a step in the same cycle.
module lfsr7_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = 7'b1101001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED_DEFAULT;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/lfsr_share_arbiter.sv
// Shares one 7-bit LFSR among NUM_REQ requesters; each grant hands out the current word.
// Round-robin by default; defining ARB_FIXED_PRIO_EN selects lowest-index-wins arbitration.
module lfsr_share_arbiter
    import lfsr_pkg::*;
#(
    parameter int                NUM_REQ      = 4,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = 7'b1101001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LFSR_W-1:0]  seed_in,
    input  logic               seed_load,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [LFSR_W-1:0]  rnd_out,
    output logic               rnd_valid,
    output logic               busy,
    output logic               period_done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    state_t              state;
    logic [LFSR_W-1:0]   seed_q;
    logic [LFSR_W-1:0]   load_val;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [CNT_W-1:0]    count;
    logic [PTR_W-1:0]    win_idx;
    logic                win_found;
    logic                lfsr_load;
    logic                lfsr_step;
`ifndef ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    win_q;
`endif

    // An all-zero seed would lock the LFSR up, so it is replaced by the default.
    assign load_val  = (seed_q == '0) ? SEED_DEFAULT : seed_q;
    assign lfsr_load = (state == SEED);
    assign lfsr_step = (state == ISSUE);

    lfsr7_core #(
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (load_val),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        logic [PTR_W-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        // Scan downward so the lowest asserted index is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = PTR_W'(i);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end
`else
    always_comb begin
        logic [PTR_W-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        // First asserted request strictly after the last winner, wrapping around.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            seed_q      <= '0;
            count       <= '0;
            gnt         <= '0;
            rnd_out     <= '0;
            rnd_valid   <= 1'b0;
            busy        <= 1'b0;
            period_done <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            ptr         <= PTR_W'(NUM_REQ - 1);
            win_q       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        seed_q <= seed_in;
                        state  <= SEED;
                        busy   <= 1'b1;
                    end else if (|req) begin
                        state <= ARB;
                        busy  <= 1'b1;
                    end
                end
                SEED: begin
                    count <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ARB: begin
                    // Outputs are loaded here so they are visible throughout ISSUE.
                    if (win_found) begin
                        gnt         <= NUM_REQ'(1) << win_idx;
                        rnd_out     <= lfsr_q;
                        rnd_valid   <= 1'b1;
                        period_done <= (count == CNT_LAST);
`ifndef ARB_FIXED_PRIO_EN
                        win_q       <= win_idx;
`endif
                        state       <= ISSUE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ISSUE: begin
                    gnt         <= '0;
                    rnd_valid   <= 1'b0;
                    period_done <= 1'b0;
                    count       <= (count == CNT_LAST) ? '0 : count + 1'b1;
`ifndef ARB_FIXED_PRIO_EN
                    ptr         <= win_q;
`endif
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
